// File: rtl/fu_result_buffer.sv
`timescale 1ns/1ps
// fu_result_buffer: per-FU FIFO staging results for the CDB; FU_BUF_BYPASS_EN adds an empty-buffer bypass
module fu_result_buffer #(
    parameter int DEPTH     = 2,
    parameter int ROB_TAG_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       squash_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ROB_TAG_W-1:0]       in_rob_tag_i,
    input  logic [XLEN-1:0]            in_v_i,
    input  logic                       in_take_branch_i,
    input  logic [XLEN-1:0]            in_branch_loc_i,
    output logic                       done_o,
    output logic [ROB_TAG_W-1:0]       rob_tag_o,
    output logic [XLEN-1:0]            v_o,
    output logic                       take_branch_o,
    output logic [XLEN-1:0]            branch_loc_o,
    input  logic                       cdb_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      v;
        logic                 tb;
        logic [XLEN-1:0]      bl;
    } ent_t;

    ent_t          mem_q [DEPTH];
    ent_t          in_e, out_e;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, push, pop, wr;

    // Handshake, pointer advance and head presentation; squash overrides everything
    always_comb begin
        in_e       = '{tag: in_rob_tag_i, v: in_v_i, tb: in_take_branch_i, bl: in_branch_loc_i};
        empty      = count_q == '0;
        in_ready_o = rst_ni & (count_q < CW'(DEPTH)) & ~squash_i;
        push       = in_valid_i & in_ready_o;
        pop        = ~empty & cdb_ack_i & ~squash_i;
`ifdef FU_BUF_BYPASS_EN
        wr         = push & ~(empty & cdb_ack_i);
        out_e      = (empty & push) ? in_e : (empty ? '0 : mem_q[head_q]);
        done_o     = ~empty | push;
`else
        wr         = push;
        out_e      = empty ? '0 : mem_q[head_q];
        done_o     = ~empty;
`endif
        head_d     = pop ? ((head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1) : head_q;
        tail_d     = wr ? ((tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1) : tail_q;
        count_d    = count_q + CW'(wr) - CW'(pop);
        if (squash_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        rob_tag_o     = out_e.tag;
        v_o           = out_e.v;
        take_branch_o = out_e.tb;
        branch_loc_o  = out_e.bl;
        count_o       = count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload captured only on push; resident entries are never rewritten
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[tail_q] <= in_e;
    end
endmodule
